// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of (pc, inst) pairs between fetch and decode.
// No bypass; flush and reset clear pointers/count only, payload storage is never reset.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush_i,
  input  logic                     push_valid_i,
  input  logic [XLEN-1:0]          push_pc_i,
  input  logic [31:0]              push_inst_i,
  output logic                     push_ready_o,
  output logic                     pop_valid_o,
  output logic [XLEN-1:0]          pop_pc_o,
  output logic [31:0]              pop_inst_o,
  input  logic                     pop_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  // Handshake flags derive from registered occupancy only
  assign push_ready_o = (count_q != CW'(DEPTH));
  assign pop_valid_o  = (count_q != CW'(0));
  assign pop_pc_o     = mem[rd_ptr_q].pc;
  assign pop_inst_o   = mem[rd_ptr_q].inst;
  assign count_o      = count_q;

  assign do_push = push_valid_i && push_ready_o && !flush_i;
  assign do_pop  = pop_valid_o && pop_ready_i && !flush_i;

  // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  // Payload write port, unreset
  always_ff @(posedge clk) begin
    if (rstn && do_push) begin
      mem[wr_ptr_q] <= '{pc: push_pc_i, inst: push_inst_i};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 64;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } ent_t;

  logic            clk;
  logic            rstn;
  logic            flush_i;
  logic            push_valid_i;
  logic [XLEN-1:0] push_pc_i;
  logic [31:0]     push_inst_i;
  logic            push_ready_o;
  logic            pop_valid_o;
  logic [XLEN-1:0] pop_pc_o;
  logic [31:0]     pop_inst_o;
  logic            pop_ready_i;
  logic [2:0]      count_o;

  int n_checks;
  int n_pass;
  ent_t model_q[$];

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush_i      (flush_i),
    .push_valid_i (push_valid_i),
    .push_pc_i    (push_pc_i),
    .push_inst_i  (push_inst_i),
    .push_ready_o (push_ready_o),
    .pop_valid_o  (pop_valid_o),
    .pop_pc_o     (pop_pc_o),
    .pop_inst_o   (pop_inst_o),
    .pop_ready_i  (pop_ready_i),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, update the reference queue from the sampled inputs, settle 1ns
  task automatic cycle();
    bit can_pop;
    bit can_push;
    @(posedge clk);
    can_pop  = pop_ready_i && (model_q.size() != 0);
    can_push = push_valid_i && (model_q.size() != DEPTH);
    if (!rstn || flush_i) begin
      model_q.delete();
    end else begin
      if (can_pop)  void'(model_q.pop_front());
      if (can_push) model_q.push_back('{pc: push_pc_i, inst: push_inst_i});
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush_i      = 1'b0;
    push_valid_i = 1'b0;
    pop_ready_i  = 1'b0;
    push_pc_i    = '0;
    push_inst_i  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
  endtask

  task automatic push_one(input logic [XLEN-1:0] pc, input logic [31:0] inst);
    push_valid_i = 1'b1;
    push_pc_i    = pc;
    push_inst_i  = inst;
    cycle();
    push_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn         = 1'b0;
    flush_i      = 1'b1;
    push_valid_i = 1'b1;
    pop_ready_i  = 1'b1;
    push_pc_i    = 64'hdead;
    cycle();
    cycle();
    idle_inputs();
    rstn = 1'b1;
    n_checks++;
    if (count_o !== 3'd0) $display("FAIL reset_count got %0d exp 0", count_o); else n_pass++;
    n_checks++;
    if (push_ready_o !== 1'b1) $display("FAIL reset_push_ready got %0b exp 1", push_ready_o); else n_pass++;
    n_checks++;
    if (pop_valid_o !== 1'b0) $display("FAIL reset_pop_valid got %0b exp 0", pop_valid_o); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    push_valid_i = 1'b1;
    push_pc_i    = 64'h1000;
    push_inst_i  = 32'h00000013;
    #1;
    n_checks++;
    if (pop_valid_o !== 1'b0) $display("FAIL single_no_bypass got %0b exp 0", pop_valid_o); else n_pass++;
    cycle();
    push_valid_i = 1'b0;
    n_checks++;
    if (pop_valid_o !== 1'b1) $display("FAIL single_valid got %0b exp 1", pop_valid_o); else n_pass++;
    n_checks++;
    if (pop_pc_o !== 64'h1000) $display("FAIL single_pc got %0h exp 1000", pop_pc_o); else n_pass++;
    n_checks++;
    if (pop_inst_o !== 32'h00000013) $display("FAIL single_inst got %0h exp 13", pop_inst_o); else n_pass++;
    n_checks++;
    if (count_o !== 3'd1) $display("FAIL single_count got %0d exp 1", count_o); else n_pass++;
    pop_ready_i = 1'b1;
    cycle();
    pop_ready_i = 1'b0;
    n_checks++;
    if (pop_valid_o !== 1'b0) $display("FAIL single_drained_valid got %0b exp 0", pop_valid_o); else n_pass++;
    n_checks++;
    if (count_o !== 3'd0) $display("FAIL single_drained_count got %0d exp 0", count_o); else n_pass++;
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 4; i++) push_one(64'(i * 4), 32'h100 + 32'(i));
    n_checks++;
    if (count_o !== 3'd4) $display("FAIL fill_count got %0d exp 4", count_o); else n_pass++;
    n_checks++;
    if (push_ready_o !== 1'b0) $display("FAIL fill_push_ready got %0b exp 0", push_ready_o); else n_pass++;
    push_one(64'h10, 32'h999);
    n_checks++;
    if (count_o !== 3'd4) $display("FAIL fill_drop_count got %0d exp 4", count_o); else n_pass++;
    // A push alongside a pop while full must still be refused
    push_valid_i = 1'b1;
    push_pc_i    = 64'h10;
    pop_ready_i  = 1'b1;
    #1;
    n_checks++;
    if (push_ready_o !== 1'b0) $display("FAIL full_pop_push_ready got %0b exp 0", push_ready_o); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (pop_pc_o !== 64'(i * 4)) $display("FAIL drain_pc[%0d] got %0h exp %0h", i, pop_pc_o, i * 4); else n_pass++;
      cycle();
      push_valid_i = 1'b0;
    end
    pop_ready_i = 1'b0;
    n_checks++;
    if (pop_valid_o !== 1'b0) $display("FAIL drain_valid got %0b exp 0", pop_valid_o); else n_pass++;
    n_checks++;
    if (count_o !== 3'd0) $display("FAIL drain_count got %0d exp 0", count_o); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [XLEN-1:0] seq [12];
    do_reset();
    for (int i = 0; i < 12; i++) seq[i] = 64'h8000 + 64'(i * 4);
    push_one(seq[0], 32'h0);
    push_one(seq[1], 32'h1);
    push_valid_i = 1'b1;
    pop_ready_i  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_pc_i   = seq[i + 2];
      push_inst_i = 32'(i + 2);
      #1;
      n_checks++;
      if (pop_pc_o !== seq[i]) $display("FAIL wrap_pc[%0d] got %0h exp %0h", i, pop_pc_o, seq[i]); else n_pass++;
      cycle();
      n_checks++;
      if (count_o !== 3'd2) $display("FAIL wrap_count[%0d] got %0d exp 2", i, count_o); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) push_one(64'h100 + 64'(i), 32'h0);
    flush_i      = 1'b1;
    push_valid_i = 1'b1;
    push_pc_i    = 64'h2000;
    pop_ready_i  = 1'b1;
    #1;
    n_checks++;
    if (pop_pc_o !== 64'h100 || count_o !== 3'd3)
      $display("FAIL flush_pre_state got pc %0h cnt %0d exp pc 100 cnt 3", pop_pc_o, count_o);
    else n_pass++;
    cycle();
    idle_inputs();
    n_checks++;
    if (count_o !== 3'd0) $display("FAIL flush_count got %0d exp 0", count_o); else n_pass++;
    n_checks++;
    if (pop_valid_o !== 1'b0) $display("FAIL flush_valid got %0b exp 0", pop_valid_o); else n_pass++;
    push_one(64'h3000, 32'h33);
    n_checks++;
    if (pop_pc_o !== 64'h3000 || count_o !== 3'd1)
      $display("FAIL flush_next got pc %0h cnt %0d exp pc 3000 cnt 1", pop_pc_o, count_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_one(64'h4000, 32'h1);
    push_one(64'h4004, 32'h2);
    rstn         = 1'b0;
    push_valid_i = 1'b1;
    push_pc_i    = 64'h4008;
    pop_ready_i  = 1'b1;
    cycle();
    rstn = 1'b1;
    idle_inputs();
    n_checks++;
    if (count_o !== 3'd0) $display("FAIL rstmid_count got %0d exp 0", count_o); else n_pass++;
    n_checks++;
    if (push_ready_o !== 1'b1) $display("FAIL rstmid_push_ready got %0b exp 1", push_ready_o); else n_pass++;
    n_checks++;
    if (pop_valid_o !== 1'b0) $display("FAIL rstmid_valid got %0b exp 0", pop_valid_o); else n_pass++;
    push_one(64'h5000, 32'h5);
    n_checks++;
    if (pop_pc_o !== 64'h5000 || count_o !== 3'd1)
      $display("FAIL rstmid_stale got pc %0h cnt %0d exp pc 5000 cnt 1", pop_pc_o, count_o);
    else n_pass++;
  endtask

  task automatic test_random();
    int unsigned bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      push_valid_i = ($urandom_range(0, 99) < 60);
      pop_ready_i  = ($urandom_range(0, 99) < 50);
      flush_i      = ($urandom_range(0, 99) < 2);
      push_pc_i    = {$urandom, $urandom};
      push_inst_i  = $urandom;
      #1;
      if (count_o > 3'(DEPTH)) bad++;
      n_checks++;
      if (count_o !== 3'(model_q.size()) ||
          pop_valid_o !== (model_q.size() != 0) ||
          push_ready_o !== (model_q.size() != DEPTH))
        $display("FAIL rand_state[%0d] got cnt %0d v %0b r %0b exp cnt %0d",
                 c, count_o, pop_valid_o, push_ready_o, model_q.size());
      else n_pass++;
      if (model_q.size() != 0) begin
        n_checks++;
        if (pop_pc_o !== model_q[0].pc || pop_inst_o !== model_q[0].inst)
          $display("FAIL rand_head[%0d] got %0h/%0h exp %0h/%0h",
                   c, pop_pc_o, pop_inst_o, model_q[0].pc, model_q[0].inst);
        else n_pass++;
      end
      cycle();
    end
    idle_inputs();
    n_checks++;
    if (bad != 0) $display("FAIL rand_count_bound got %0d overflows exp 0", bad); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn     = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_single();
    test_fill_drain();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
